sevenseg_scan_driver: RTL and testbench

//  Time-multiplexed driver for a DIGITS-wide common-anode/-cathode 7-segment display.

---
 rtl/sevenseg_scan_driver.sv | 190 +++++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Time-multiplexed driver for a DIGITS-wide 7-segment display. Holds a hex
//   word, scans one digit per slot of CLK_DIV cycles and decodes each nibble
//   to segments a..g. Adds per-digit decimal points, leading-zero blanking,
//   a dead time with all anodes off at the start of each slot (ghost
//   suppression), and frame-aligned updates so a digit never tears.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load        in   strobe: capture value/dp_in this cycle
//   value       in   [4*DIGITS-1:0] hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in       in   [DIGITS-1:0] decimal point per digit, 1 = lit
//   blank       in   1 = all digits dark (scan keeps running)
//   seg         out  [6:0] {a,b,c,d,e,f,g}, polarity per SEG_ACT_LOW
//   dp          out  decimal point, polarity per SEG_ACT_LOW
//   an          out  [DIGITS-1:0] digit enables, polarity per AN_ACT_LOW
//   frame_done  out  1-cycle pulse after each frame boundary
module sevenseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 1000,
  parameter int DEAD_CYC    = 16,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W   = (DIGITS > 1)  ? $clog2(DIGITS)  : 1;
  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] DEAD_END  = PRESC_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(DIGITS - 1);

  // Pin levels that mean "off"; active-high levels are XORed with these.
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACT_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACT_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0] active_val_q, active_val_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                boundary;
  logic [3:0]          nib;
  logic                dp_sel;
  logic [DIGITS-1:0]   an_sel;
  logic                upper_zero;
  logic                lit;
  logic                lz_hit;

  // Scan timing
  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Pending/active double buffer. Active only moves on a frame boundary so a
  // frame always shows one consistent word; a load coinciding with the
  // boundary bypasses the pending stage.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
    if (boundary) begin
      pend_flag_d = 1'b0;
      if (load) begin
        active_val_d = value;
        active_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        active_val_d = pend_val_q;
        active_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_flag_d = 1'b1;
    end
  end

  // Slot output, computed from the current scan position and registered.
  always_comb begin
    nib        = 4'h0;
    dp_sel     = 1'b0;
    an_sel     = '0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = active_val_q[i*4 +: 4];
        dp_sel    = active_dp_q[i];
        an_sel[i] = 1'b1;
      end
      // Leading-zero test: this digit and every more-significant one are 0.
      if ((IDX_W'(i) >= idx_q) && (active_val_q[i*4 +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    lit          = (presc_q >= DEAD_END) && !blank;
    lz_hit       = LZ_BLANK && (idx_q != '0) && upper_zero;
    seg_d        = ((lit && !lz_hit) ? hex_to_seg(nib) : 7'h00) ^ SEG_OFF;
    dp_d         = (lit && dp_sel) ^ SEG_ACT_LOW;
    an_d         = (lit ? an_sel : '0) ^ AN_OFF;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACT_LOW;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver. Two instances share stimulus:
//   dut_a: LZ blanking on, segments active-high, anodes active-low
//   dut_b: LZ blanking off, segments active-low, anodes active-high
module tb_sevenseg_scan_driver;

  localparam int DIGITS = 4;
  localparam int CDIV   = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = DIGITS * CDIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic       fd_a, fd_b;

  sevenseg_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CDIV), .DEAD_CYC(DEAD),
    .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
  );

  sevenseg_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CDIV), .DEAD_CYC(DEAD),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b0), .LZ_BLANK(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
      4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
      4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
      4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  // Reference model: scan position is pure arithmetic on the number of
  // clock edges since reset; the displayed word is swapped at frame ends.
  int unsigned m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pflag;

  task automatic model_reset();
    m_t = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pflag = 1'b0;
  endtask

  // Expected active-high {seg,dp,an,fd} for the edge at scan position m_t.
  function automatic logic [12:0] ref_out(input bit lz_en);
    int unsigned presc, idx;
    logic lit, lz;
    logic [6:0] s;
    logic [3:0] a;
    logic d;
    presc = m_t % CDIV;
    idx   = (m_t / CDIV) % DIGITS;
    lit   = (presc >= DEAD) && !blank;
    lz    = lz_en && (idx != 0) && ((m_act >> (4 * idx)) == 16'h0);
    s     = (lit && !lz) ? ref_dec(4'((m_act >> (4 * idx)) & 16'hF)) : 7'h00;
    d     = lit && m_act_dp[idx];
    a     = lit ? 4'(1 << idx) : 4'h0;
    return {s, d, a, (m_t % FRAME) == FRAME - 1};
  endfunction

  typedef struct {
    logic [15:0] val;
    logic [27:0] exp_a;  // {d3,d2,d1,d0} active-high segments, LZ on
    logic [27:0] exp_b;  // same with LZ off
  } vec_t;

  vec_t tbl [7];
  bit   tbl_on  = 1'b0;
  int   tbl_cur = 0;

  task automatic cycle();
    logic [12:0] ea, eb;
    int unsigned presc_pre, idx_pre;
    bit bnd;
    ea = ref_out(1'b1);
    eb = ref_out(1'b0);
    presc_pre = m_t % CDIV;
    idx_pre   = (m_t / CDIV) % DIGITS;
    bnd = (m_t % FRAME) == FRAME - 1;
    @(posedge clk);
    if (bnd) begin
      if (load) begin m_act = value; m_act_dp = dp_in; end
      else if (m_pflag) begin m_act = m_pend; m_act_dp = m_pend_dp; end
      m_pflag = 1'b0;
    end else if (load) begin
      m_pflag = 1'b1;
    end
    if (load) begin m_pend = value; m_pend_dp = dp_in; end
    m_t++;
    #1;
    check("scan_a", {19'd0, seg_a, dp_a, an_a, fd_a},
          {19'd0, ea[12:6], ea[5], ~ea[4:1], ea[0]});
    check("scan_b", {19'd0, seg_b, dp_b, an_b, fd_b},
          {19'd0, ~eb[12:6], ~eb[5], eb[4:1], eb[0]});
    if (tbl_on && presc_pre == 5) begin
      check("tbl_seg_a", {25'd0, seg_a}, {25'd0, tbl[tbl_cur].exp_a[idx_pre*7 +: 7]});
      check("tbl_seg_b", {25'd0, seg_b}, {25'd0, ~tbl[tbl_cur].exp_b[idx_pre*7 +: 7]});
    end
  endtask

  task automatic run_to_frame_start();
    for (int i = 0; i < FRAME && (m_t % FRAME) != 0; i++) cycle();
  endtask

  task automatic run_to_boundary();
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) cycle();
  endtask

  task automatic check_inactive(input string nm);
    check({nm, "_a"}, {19'd0, seg_a, dp_a, an_a, fd_a}, {19'd0, 7'h00, 1'b0, 4'hF, 1'b0});
    check({nm, "_b"}, {19'd0, seg_b, dp_b, an_b, fd_b}, {19'd0, 7'h7F, 1'b1, 4'h0, 1'b0});
  endtask

  int cnt_fd, cnt_lit, cnt_dp, cnt_dp_bad;

  initial begin
    tbl[0] = '{16'h12AF, {7'h30, 7'h6D, 7'h77, 7'h47}, {7'h30, 7'h6D, 7'h77, 7'h47}};
    tbl[1] = '{16'h0005, {7'h00, 7'h00, 7'h00, 7'h5B}, {7'h7E, 7'h7E, 7'h7E, 7'h5B}};
    tbl[2] = '{16'h0000, {7'h00, 7'h00, 7'h00, 7'h7E}, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
    tbl[3] = '{16'h0300, {7'h00, 7'h79, 7'h7E, 7'h7E}, {7'h7E, 7'h79, 7'h7E, 7'h7E}};
    tbl[4] = '{16'h8000, {7'h7F, 7'h7E, 7'h7E, 7'h7E}, {7'h7F, 7'h7E, 7'h7E, 7'h7E}};
    tbl[5] = '{16'hCDE9, {7'h4E, 7'h3D, 7'h4F, 7'h7B}, {7'h4E, 7'h3D, 7'h4F, 7'h7B}};
    tbl[6] = '{16'h0B06, {7'h00, 7'h1F, 7'h7E, 7'h5F}, {7'h7E, 7'h1F, 7'h7E, 7'h5F}};

    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank = 1'b0;
    model_reset();
    #12;
    check_inactive("reset");
    #10 rst_n = 1'b1;  // released between edges (t=22)

    // Dead time then digit 0 of the reset word.
    repeat (2) cycle();
    check("dead_an", {28'd0, an_a}, {28'd0, 4'hF});
    cycle();
    check("first_lit_an", {28'd0, an_a}, {28'd0, 4'hE});
    check("first_lit_seg", {25'd0, seg_a}, {25'd0, 7'h7E});
    repeat (FRAME) cycle();

    // Table vectors: load mid-frame, expect each digit in the following frame.
    for (int v = 0; v < 7; v++) begin
      repeat (5 + v) cycle();
      load = 1'b1; value = tbl[v].val; dp_in = 4'($urandom);
      cycle();
      load = 1'b0;
      run_to_frame_start();
      tbl_cur = v; tbl_on = 1'b1;
      repeat (FRAME) cycle();
      tbl_on = 1'b0;
    end

    // Load on the exact boundary cycle shows in the next slot.
    run_to_boundary();
    load = 1'b1; value = 16'h4321; dp_in = 4'h0;
    cycle();
    load = 1'b0;
    repeat (DEAD + 1) cycle();
    check("bnd_load_seg", {25'd0, seg_a}, {25'd0, 7'h30});

    // Two loads in one frame: the second wins.
    run_to_frame_start();
    load = 1'b1; value = 16'h1111;
    cycle();
    load = 1'b0;
    repeat (4) cycle();
    load = 1'b1; value = 16'h7777;
    cycle();
    load = 1'b0;
    run_to_frame_start();
    repeat (DEAD + 1) cycle();
    check("last_load_seg", {25'd0, seg_a}, {25'd0, 7'h70});

    // Blank for one full frame: dark pins, frame_done still pulses.
    run_to_frame_start();
    blank = 1'b1;
    cnt_fd = 0; cnt_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (fd_a) cnt_fd++;
      if (an_a != 4'hF || seg_a != 7'h00) cnt_lit++;
    end
    blank = 1'b0;
    check("blank_lit_cycles", cnt_lit, 0);
    check("blank_fd_pulses", cnt_fd, 1);

    // Decimal point only in slot 2.
    load = 1'b1; value = 16'h1234; dp_in = 4'b0100;
    cycle();
    load = 1'b0;
    run_to_frame_start();
    repeat (FRAME) cycle();
    cnt_dp = 0; cnt_dp_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (dp_a) begin
        cnt_dp++;
        if (an_a != 4'b1011) cnt_dp_bad++;
      end
    end
    check("dp_cycles", cnt_dp, CDIV - DEAD);
    check("dp_wrong_slot", cnt_dp_bad, 0);

    // Async reset mid-slot.
    repeat (CDIV + 4) cycle();
    #3 rst_n = 1'b0;
    #1 check_inactive("async_rst");
    model_reset();
    load = 1'b0; value = '0; dp_in = '0;
    @(posedge clk);
    #1 check_inactive("rst_held");
    #2 rst_n = 1'b1;
    repeat (DEAD) cycle();
    cycle();
    check("restart_an_a", {28'd0, an_a}, {28'd0, 4'hE});
    check("restart_an_b", {28'd0, an_b}, {28'd0, 4'h1});
    check("restart_seg_b", {25'd0, seg_b}, {25'd0, 7'h01});

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 15) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 99) == 0) blank = ~blank;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
